// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated frequency counter for slow external signals
// Purpose: counts rising edges of sig_in over a window of GATE_CYCLES clk_in
//   cycles and reports the count, one-shot or continuously re-armed.
// Optional feature macro: FREQ_BCD_EN adds a CONV state running a serial
//   double-dabble conversion and the freq_bcd output.
// Ports:
//   clk_in      system clock (only clock)
//   rst_n       asynchronous active-low reset
//   sig_in      measured signal, asynchronous to clk_in
//   start       level, sampled in IDLE, begins a measurement
//   stop        aborts a measurement / leaves continuous mode
//   cont        re-arm automatically after each result
//   busy        high whenever not IDLE
//   freq_out    last completed edge count
//   freq_valid  one-cycle pulse when freq_out updates
//   ovf         last result saturated (or exceeded BCD range)
//   freq_bcd    BCD of freq_out (FREQ_BCD_EN only)
module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 24,
  parameter int BCD_DIGITS  = 8
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] freq_out,
  output logic             freq_valid,
  output logic             ovf
`ifdef FREQ_BCD_EN
  ,
  output logic [4*BCD_DIGITS-1:0] freq_bcd
`endif
);

  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  if (GATE_CYCLES < 2 || BCD_DIGITS < 1) begin : g_param_check
    $error("freq_meter: GATE_CYCLES must be >= 2 and BCD_DIGITS >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_GATE = 3'd2,
    S_DONE = 3'd3
`ifdef FREQ_BCD_EN
    ,
    S_CONV = 3'd4
`endif
  } state_t;

  state_t state, state_nxt;

  logic             sync1, sync2, sync3, rise;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_nxt;
  logic             sat, sat_nxt;
  logic             gate_last;

  // Two flops for metastability, third flop for edge detection.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise      = sync2 & ~sync3;
  assign gate_last = (gate_cnt == GATE_LAST);
  assign busy      = (state != S_IDLE);

  // Saturating edge counter: sat marks an edge lost at all-ones.
  always_comb begin
    edge_cnt_nxt = edge_cnt;
    sat_nxt      = sat;
    if (rise) begin
      if (&edge_cnt) sat_nxt = 1'b1;
      else           edge_cnt_nxt = edge_cnt + CNT_W'(1);
    end
  end

`ifdef FREQ_BCD_EN
  localparam int CW = $clog2(CNT_W + 1);
  localparam logic [CW-1:0] CONV_LAST = CW'(CNT_W - 1);
  localparam logic [63:0] BCD_MAX = (64'd10 ** BCD_DIGITS) - 64'd1;

  logic [CNT_W-1:0]        conv_sh;
  logic [4*BCD_DIGITS-1:0] bcd, bcd_adj, bcd_shifted;
  logic [CW-1:0]           conv_cnt;
  logic                    conv_last, bcd_ovf;

  assign conv_last = (conv_cnt == CONV_LAST);
  assign bcd_ovf   = (64'(edge_cnt) > BCD_MAX);

  // Add 3 to every digit >= 5 before the shift (double dabble).
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end
  assign bcd_shifted = {bcd_adj[4*BCD_DIGITS-2:0], conv_sh[CNT_W-1]};
`endif

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start && !stop) state_nxt = S_ARM;
      S_ARM:  state_nxt = S_GATE;
      S_GATE: begin
        if (stop) state_nxt = S_IDLE;
`ifdef FREQ_BCD_EN
        else if (gate_last) state_nxt = S_CONV;
`else
        else if (gate_last) state_nxt = S_DONE;
`endif
      end
`ifdef FREQ_BCD_EN
      S_CONV: begin
        if (stop)           state_nxt = S_IDLE;
        else if (conv_last) state_nxt = S_DONE;
      end
`endif
      S_DONE: state_nxt = (cont && !stop) ? S_ARM : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Results are loaded on the edge entering DONE so freq_valid, freq_out
  // and ovf are all visible during the DONE cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      sat        <= 1'b0;
      freq_out   <= '0;
      ovf        <= 1'b0;
      freq_valid <= 1'b0;
`ifdef FREQ_BCD_EN
      conv_sh    <= '0;
      bcd        <= '0;
      conv_cnt   <= '0;
      freq_bcd   <= '0;
`endif
    end else begin
      freq_valid <= 1'b0;
      case (state)
        S_ARM: begin
          edge_cnt <= '0;
          gate_cnt <= '0;
          sat      <= 1'b0;
        end
        S_GATE: if (!stop) begin
          edge_cnt <= edge_cnt_nxt;
          sat      <= sat_nxt;
          gate_cnt <= gate_cnt + GW'(1);
          if (gate_last) begin
`ifdef FREQ_BCD_EN
            conv_sh  <= edge_cnt_nxt;
            bcd      <= '0;
            conv_cnt <= '0;
`else
            freq_out   <= edge_cnt_nxt;
            ovf        <= sat_nxt;
            freq_valid <= 1'b1;
`endif
          end
        end
`ifdef FREQ_BCD_EN
        S_CONV: if (!stop) begin
          bcd      <= bcd_shifted;
          conv_sh  <= {conv_sh[CNT_W-2:0], 1'b0};
          conv_cnt <= conv_cnt + CW'(1);
          if (conv_last) begin
            freq_out   <= edge_cnt;
            ovf        <= sat | bcd_ovf;
            freq_bcd   <= bcd_ovf ? {BCD_DIGITS{4'h9}} : bcd_shifted;
            freq_valid <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// tb/tb_freq_meter.sv - self-checking bench for freq_meter
module tb_freq_meter;
  localparam int G = 1000;
  localparam int W = 12;
`ifdef FREQ_BCD_EN
  localparam int LAT = G + 2 + W;
`else
  localparam int LAT = G + 2;
`endif

  logic clk_in = 1'b0;
  logic rst_n = 1'b0, sig_in = 1'b0, start = 1'b0, stop = 1'b0, cont = 1'b0;
  logic busy, freq_valid, ovf;
  logic [W-1:0] freq_out;
  logic busy8, valid8, ovf8;
  logic [7:0] freq8;
`ifdef FREQ_BCD_EN
  logic [11:0] freq_bcd, bcd8;
  logic start_b = 1'b0;
  logic busy_b, valid_b, ovf_b;
  logic [11:0] freq_b, bcd_b;
`endif

  int sig_period = 0;
  int sig_phase = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (sig_period == 0) begin
      sig_phase = 0;
      sig_in = 1'b0;
    end else begin
      sig_phase = (sig_phase + 1 >= sig_period) ? 0 : sig_phase + 1;
      sig_in = (sig_phase < sig_period / 2);
    end
  end

  freq_meter #(.GATE_CYCLES(G), .CNT_W(W), .BCD_DIGITS(3)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start), .stop(stop),
    .cont(cont), .busy(busy), .freq_out(freq_out), .freq_valid(freq_valid), .ovf(ovf)
`ifdef FREQ_BCD_EN
    , .freq_bcd(freq_bcd)
`endif
  );

  freq_meter #(.GATE_CYCLES(G), .CNT_W(8), .BCD_DIGITS(3)) dut8 (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start), .stop(stop),
    .cont(cont), .busy(busy8), .freq_out(freq8), .freq_valid(valid8), .ovf(ovf8)
`ifdef FREQ_BCD_EN
    , .freq_bcd(bcd8)
`endif
  );

`ifdef FREQ_BCD_EN
  freq_meter #(.GATE_CYCLES(2400), .CNT_W(W), .BCD_DIGITS(3)) dut_big (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .start(start_b), .stop(1'b0),
    .cont(1'b0), .busy(busy_b), .freq_out(freq_b), .freq_valid(valid_b), .ovf(ovf_b),
    .freq_bcd(bcd_b)
  );
`endif

  typedef struct {
    int          period;
    int          exp_freq;
    bit          exp_ovf;
    int          exp_f8;
    bit          exp_o8;
    logic [11:0] exp_bcd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_in);
    start = 1'b1;
    @(posedge clk_in);
    #1;
    start = 1'b0;
  endtask

  // n = cycles after the start-sampling edge until freq_valid is seen.
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (freq_valid !== 1'b1 && n < budget) begin
      @(posedge clk_in);
      #1;
      n++;
    end
  endtask

  task automatic count_valid(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk_in);
      #1;
      if (freq_valid === 1'b1) cnt++;
    end
  endtask

  initial begin
    vec_t vecs[8];
    int n;
    int cnt;
    vecs[0] = '{100,  10, 1'b0,  10, 1'b0, 12'h010};
    vecs[1] = '{50,   20, 1'b0,  20, 1'b0, 12'h020};
    vecs[2] = '{2,   500, 1'b0, 255, 1'b1, 12'h500};
    vecs[3] = '{40,   25, 1'b0,  25, 1'b0, 12'h025};
    vecs[4] = '{8,   125, 1'b0, 125, 1'b0, 12'h125};
    vecs[5] = '{4,   250, 1'b0, 250, 1'b0, 12'h250};
    vecs[6] = '{1000,  1, 1'b0,   1, 1'b0, 12'h001};
    vecs[7] = '{0,     0, 1'b0,   0, 1'b0, 12'h000};

    #1;
    check("reset_busy", busy, 0);
    check("reset_freq_out", freq_out, 0);
    check("reset_valid", freq_valid, 0);
    check("reset_ovf", ovf, 0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      sig_period = vecs[i].period;
      repeat (10) @(negedge clk_in);
      pulse_start();
      wait_valid(LAT + 20, n);
      check("vec_latency", n + 1, LAT);
      check("vec_freq_out", freq_out, vecs[i].exp_freq);
      check("vec_ovf", ovf, vecs[i].exp_ovf);
      check("vec_freq8", freq8, vecs[i].exp_f8);
      check("vec_ovf8", ovf8, vecs[i].exp_o8);
      check("vec_busy_at_valid", busy, 1);
`ifdef FREQ_BCD_EN
      check("vec_bcd", freq_bcd, vecs[i].exp_bcd);
`endif
      @(posedge clk_in);
      #1;
      check("vec_busy_drop", busy, 0);
      check("vec_valid_width", freq_valid, 0);
    end

    // Continuous mode, then leave it by dropping cont mid-measurement.
    sig_period = 50;
    cont = 1'b1;
    repeat (10) @(negedge clk_in);
    pulse_start();
    wait_valid(LAT + 20, n);
    check("cont_first_latency", n + 1, LAT);
    check("cont_first_freq", freq_out, 20);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_in);
      #1;
      wait_valid(LAT + 20, n);
      check("cont_period", n + 1, LAT);
      check("cont_freq", freq_out, 20);
    end
    @(posedge clk_in);
    #1;
    cont = 1'b0;
    wait_valid(LAT + 20, n);
    check("cont_last_period", n + 1, LAT);
    check("cont_last_freq", freq_out, 20);
    @(posedge clk_in);
    #1;
    check("cont_exit_idle", busy, 0);
    count_valid(LAT + 50, cnt);
    check("cont_no_extra_result", cnt, 0);

    // Abort at gate cycle ~500.
    sig_period = 100;
    repeat (10) @(negedge clk_in);
    pulse_start();
    repeat (502) @(posedge clk_in);
    #1;
    check("abort_busy_before", busy, 1);
    @(negedge clk_in);
    stop = 1'b1;
    @(posedge clk_in);
    #1;
    check("abort_idle_next", busy, 0);
    stop = 1'b0;
    count_valid(LAT + 50, cnt);
    check("abort_no_valid", cnt, 0);
    check("abort_freq_kept", freq_out, 20);

    // start and stop together in IDLE.
    @(negedge clk_in);
    start = 1'b1;
    stop = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    check("start_stop_idle", busy, 0);
    start = 1'b0;
    stop = 1'b0;

    // start pulses during GATE are ignored.
    pulse_start();
    n = 0;
    while (freq_valid !== 1'b1 && n < LAT + 20) begin
      start = (n == 300 || n == 600);
      @(posedge clk_in);
      #1;
      n++;
    end
    start = 1'b0;
    check("restart_ignored_latency", n + 1, LAT);
    check("restart_ignored_freq", freq_out, 10);
    @(posedge clk_in);
    #1;
    check("restart_ignored_idle", busy, 0);

    // Asynchronous reset mid-gate clears outputs before any clock edge.
    pulse_start();
    repeat (400) @(posedge clk_in);
    @(negedge clk_in);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_freq", freq_out, 0);
    check("rst_mid_valid", freq_valid, 0);
    check("rst_mid_ovf", ovf, 0);
    check("rst_mid_freq8", freq8, 0);
`ifdef FREQ_BCD_EN
    check("rst_mid_bcd", freq_bcd, 0);
`endif
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;

`ifdef FREQ_BCD_EN
    // 1200 edges exceed three BCD digits.
    sig_period = 2;
    repeat (10) @(negedge clk_in);
    start_b = 1'b1;
    @(posedge clk_in);
    #1;
    start_b = 1'b0;
    n = 0;
    while (valid_b !== 1'b1 && n < 2400 + 2 + W + 20) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    check("bcd_big_latency", n + 1, 2400 + 2 + W);
    check("bcd_big_freq", freq_b, 1200);
    check("bcd_big_bcd", bcd_b, 12'h999);
    check("bcd_big_ovf", ovf_b, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Gated frequency counter. It measures an external slow signal against the board clock. It is the inverse of the team's clock divider: the divider makes known-rate ticks from clk_in, and this block recovers an unknown rate from a signal.
- Used to self-check the divided clocks (1 kHz / 50 Hz / 0.25 Hz) and external sensor pulse trains in the elevator experiment.
- Counts rising edges of sig_in over a fixed gate window of GATE_CYCLES clk_in periods, then reports the count.

Parameters:
- GATE_CYCLES, 50000000, gate window length in clk_in cycles (1 s at 50 MHz). Must be ≥ 2.
- CNT_W, 24, width of the edge count and freq_out.
- BCD_DIGITS, 8, BCD digits produced when FREQ_BCD_EN is defined.

Ports:
- clk_in  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- sig_in  input  1  measured signal, asynchronous to clk_in.
- start  input  1  level, sampled in IDLE; begins a measurement.
- stop  input  1  aborts a measurement, or leaves continuous mode.
- cont  input  1  1 = re-arm automatically after each result.
- busy  output  1  1 whenever state != IDLE.
- freq_out  output  CNT_W  last completed edge count.
- freq_valid  output  1  one-cycle pulse when freq_out updates.
- ovf  output  1  last result saturated; valid with freq_out.
- freq_bcd  output  4*BCD_DIGITS  BCD of freq_out; present only with FREQ_BCD_EN.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, busy=0, freq_out=0, freq_valid=0, ovf=0, freq_bcd=0, synchronizer and edge-detect flops=0, all counters=0.
- sig_in passes through a 2-flop synchronizer, then a third flop.
  - rise = sync2 & ~sync3.
  - An edge on sig_in is seen at rise 2–3 cycles later.
- IDLE:
  - start=1 & stop=0 → ARM.
  - stop=1 has priority; the block stays in IDLE.
- ARM (1 cycle): clears edge_cnt, gate_cnt and the sat flag. A rise in this cycle is not counted. → GATE.
- GATE lasts exactly GATE_CYCLES cycles. gate_cnt runs 0..GATE_CYCLES-1 and is $clog2(GATE_CYCLES) bits wide.
  - Each cycle with rise=1 increments edge_cnt.
  - At all-ones, edge_cnt holds and sat is set.
  - stop=1 → IDLE immediately; freq_out, ovf and freq_valid are unchanged.
  - On the last gate cycle → DONE, or → CONV when FREQ_BCD_EN is defined.
- DONE (1 cycle):
  - freq_out<=edge_cnt, ovf<=sat, freq_valid=1 (registered, high for exactly this cycle).
  - Exit: cont=1 & stop=0 → ARM; otherwise → IDLE.
- Latency: without BCD, freq_valid is high GATE_CYCLES+2 cycles after the clk edge that samples start.
  - In continuous mode, results repeat every GATE_CYCLES+2 cycles.
- start while busy=1 is ignored. Changes to cont take effect only at DONE.
- Max countable rate is clk_in/2, from the synchronizer. Faster input gives undefined counts, not a hang.

Optional Feature:
- Macro: FREQ_BCD_EN.
- Defined:
  - State CONV is inserted between GATE and DONE.
  - CONV runs a sequential shift-add-3 (double-dabble) conversion of edge_cnt, one bit per cycle, CNT_W cycles.
  - freq_bcd is loaded in DONE together with freq_out, so freq_valid is delayed by CNT_W cycles.
  - If edge_cnt > 10^BCD_DIGITS-1, freq_bcd becomes all 9s and ovf=1.
  - stop during CONV → IDLE; outputs are unchanged.
- Undefined: no CONV state, no freq_bcd port, no converter logic.

Test Plan (GATE_CYCLES=1000, CNT_W=12; BCD_DIGITS=3 for the BCD case):
- Period test: reset, start pulse, sig_in period 100 clk with rising edges mid-window → freq_valid once at start+1002 cycles, freq_out=10, ovf=0, busy drops next cycle.
- Saturation: sig_in period 2 clk with CNT_W=8 → freq_out=255, ovf=1.
- Abort and reset mid-gate:
  - stop asserted at gate cycle 500 → IDLE next cycle, no freq_valid, freq_out keeps the prior value.
  - rst_n low mid-gate → all outputs 0 immediately.
- Continuous mode: cont=1, sig_in period 50 → freq_valid pulses every 1002 cycles with freq_out=20. Deassert cont → exactly one more result, then IDLE.
- start/stop edge cases:
  - start and stop both high in IDLE → stays IDLE, busy=0.
  - start pulses during GATE → ignored, result timing unchanged.
- BCD (FREQ_BCD_EN, CNT_W=12):
  - 10 edges → freq_bcd=0x010, freq_valid at start+1014.
  - 1200 edges (BCD_DIGITS=3) → freq_bcd=0x999, ovf=1.
